// File: rtl/y86_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : y86_pkg                                                    |
// | Brief    : Shared encodings for the Y86-64 fetch/decode/execute core: |
// |            icodes, register ids, ALU ops, condition codes, and the    |
// |            instruction-length helper.                                 |
// | Options  : Y86_IADDQ_EN makes icode C (iaddq) a 10-byte instruction  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package y86_pkg;

  // Instruction codes (byte0 [7:4])
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  // Register identifiers
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Condition function codes for cmovXX / jXX (ifun)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // ALU operations; encoding matches the OPq ifun so ifun[1:0] maps directly
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  // Byte length of an instruction from its icode; unknown icodes count as 1
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len = 4'd10;
      I_JXX, I_CALL:                    len = 4'd9;
`ifdef Y86_IADDQ_EN
      I_IADDQ:                          len = 4'd10;
`endif
      default:                          len = 4'd1;
    endcase
    return len;
  endfunction

endpackage : y86_pkg
`default_nettype wire

// File: rtl/y86_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : y86_alu                                                    |
// | Brief    : 64-bit ALU computing b OP a (add, sub, and, xor) together  |
// |            with the zero/sign/overflow flags of the result.           |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module y86_alu
  import y86_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_op_e     op,
  output logic [63:0] result,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  // Result and flags; subtraction is b - a so OPq reads as valB OP valA
  always_comb begin
    result = 64'd0;
    of     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = b + a;
        of     = (a[63] == b[63]) && (result[63] != a[63]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (a[63] != b[63]) && (result[63] != b[63]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = 64'd0;
    endcase
    zf = (result == 64'd0);
    sf = result[63];
  end

endmodule : y86_alu
`default_nettype wire

// File: rtl/y86_fde_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : y86_fde_core                                               |
// | Brief    : Single-cycle Y86-64 fetch/decode/execute stage. Decodes    |
// |            the instruction at pc, reads operands from the external    |
// |            register file, computes valE/cnd and holds the CC flags.   |
// | Options  : Y86_IADDQ_EN enables iaddq (icode C); otherwise C is      |
// |            reported as an invalid instruction.                        |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module y86_fde_core
  import y86_pkg::*;
#(
  parameter int IMEM_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  pc,
  input  logic [79:0]  instr_bytes,
  input  logic [959:0] reg_flat,
  output logic [3:0]   icode,
  output logic [3:0]   ifun,
  output logic [3:0]   rA,
  output logic [3:0]   rB,
  output logic [63:0]  valC,
  output logic [63:0]  valP,
  output logic [63:0]  valA,
  output logic [63:0]  valB,
  output logic [63:0]  valE,
  output logic         cnd,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         halt,
  output logic         imem_error,
  output logic         invalid_instr
);

  logic [3:0]  len;
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic        bad_code;
  logic        has_regs;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  alu_op_e     alu_op;
  logic [63:0] alu_res;
  logic        alu_zf;
  logic        alu_sf;
  logic        alu_of;
  logic        cc_load;
  logic        zf_d, sf_d, of_d;
  logic        zf_q, sf_q, of_q;

  // Register file read; id F reads as zero
  function automatic logic [63:0] read_reg(input logic [959:0] rf, input logic [3:0] idx);
    if (idx == RNONE) return 64'd0;
    return rf[{idx, 6'd0} +: 64];
  endfunction

  // Fetch/decode: fields, length, constant word, next pc, fetch-range and legality checks
  always_comb begin
    icode = instr_bytes[7:4];
    ifun  = instr_bytes[3:0];
    len   = instr_len(icode);
    valP  = pc + 64'(len);

    has_regs = 1'b0;
    valC     = 64'd0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: has_regs = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        has_regs = 1'b1;
        valC     = instr_bytes[79:16];
      end
      I_JXX, I_CALL: valC = instr_bytes[71:8];
`ifdef Y86_IADDQ_EN
      I_IADDQ: begin
        has_regs = 1'b1;
        valC     = instr_bytes[79:16];
      end
`endif
      default: ;
    endcase
    rA = has_regs ? instr_bytes[15:12] : RNONE;
    rB = has_regs ? instr_bytes[11:8]  : RNONE;

    // Compare in 65 bits so a pc near 2^64 cannot wrap into the legal range
    imem_error = ({1'b0, pc} + 65'(len)) > 65'(IMEM_SIZE);

    case (icode)
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_CALL, I_RET, I_PUSHQ, I_POPQ: bad_code = (ifun != 4'h0);
      I_OPQ:                          bad_code = (ifun > 4'h3);
      I_RRMOVQ, I_JXX:                bad_code = (ifun > 4'h6);
`ifdef Y86_IADDQ_EN
      I_IADDQ:                        bad_code = (ifun != 4'h0) || (instr_bytes[15:12] != RNONE);
`endif
      default:                        bad_code = 1'b1;
    endcase
    invalid_instr = bad_code && !imem_error;
    halt          = (icode == I_HALT) && !bad_code && !imem_error;
  end

  // Operand source selection and register reads
  always_comb begin
    case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA;
      I_RET, I_POPQ:                      src_a = RSP;
      default:                            src_a = RNONE;
    endcase
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = rB;
`ifdef Y86_IADDQ_EN
      I_IADDQ:                            src_b = rB;
`endif
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     src_b = RSP;
      default:                            src_b = RNONE;
    endcase
    valA = read_reg(reg_flat, src_a);
    valB = read_reg(reg_flat, src_b);
  end

  // Every valE is formed by the one ALU; steer its operands per icode
  always_comb begin
    alu_a  = 64'd0;
    alu_b  = 64'd0;
    alu_op = ALU_ADD;
    case (icode)
      I_RRMOVQ: alu_a = valA;
      I_IRMOVQ: alu_a = valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = valC;
        alu_b = valB;
      end
      I_OPQ: begin
        alu_a  = valA;
        alu_b  = valB;
        alu_op = alu_op_e'(ifun[1:0]);
      end
      I_CALL, I_PUSHQ: begin
        alu_a  = 64'd8;
        alu_b  = valB;
        alu_op = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a = 64'd8;
        alu_b = valB;
      end
`ifdef Y86_IADDQ_EN
      I_IADDQ: begin
        alu_a = valC;
        alu_b = valB;
      end
`endif
      default: ;
    endcase
  end

  y86_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  assign valE = alu_res;

  // Branch / conditional-move outcome from the current flags
  always_comb begin
    cnd = 1'b0;
    if (icode == I_RRMOVQ || icode == I_JXX) begin
      case (ifun)
        C_YES:   cnd = 1'b1;
        C_LE:    cnd = (sf_q ^ of_q) | zf_q;
        C_L:     cnd = sf_q ^ of_q;
        C_E:     cnd = zf_q;
        C_NE:    cnd = !zf_q;
        C_GE:    cnd = !(sf_q ^ of_q);
        C_G:     cnd = !(sf_q ^ of_q) && !zf_q;
        default: cnd = 1'b0;
      endcase
    end
  end

  // Next CC: ALU flags of a legal, fully fetched arithmetic instruction
  always_comb begin
`ifdef Y86_IADDQ_EN
    cc_load = (icode == I_OPQ || icode == I_IADDQ) && !imem_error && !bad_code;
`else
    cc_load = (icode == I_OPQ) && !imem_error && !bad_code;
`endif
    zf_d = cc_load ? alu_zf : zf_q;
    sf_d = cc_load ? alu_sf : sf_q;
    of_d = cc_load ? alu_of : of_q;
  end

  // Architectural condition-code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;

endmodule : y86_fde_core
`default_nettype wire

// File: tb/tb_y86_fde_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_y86_fde_core                                            |
// | Brief    : Directed self-checking bench for y86_fde_core.             |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_y86_fde_core;

  logic         clk;
  logic         rst_n;
  logic [63:0]  pc;
  logic [79:0]  instr_bytes;
  logic [959:0] reg_flat;
  logic [3:0]   icode, ifun, rA, rB;
  logic [63:0]  valC, valP, valA, valB, valE;
  logic         cnd, zf, sf, of;
  logic         halt, imem_error, invalid_instr;

  int n_cmp  = 0;
  int n_fail = 0;

  y86_fde_core #(.IMEM_SIZE(1024)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .instr_bytes   (instr_bytes),
    .reg_flat      (reg_flat),
    .icode         (icode),
    .ifun          (ifun),
    .rA            (rA),
    .rB            (rB),
    .valC          (valC),
    .valP          (valP),
    .valA          (valA),
    .valB          (valB),
    .valE          (valE),
    .cnd           (cnd),
    .zf            (zf),
    .sf            (sf),
    .of            (of),
    .halt          (halt),
    .imem_error    (imem_error),
    .invalid_instr (invalid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input int idx, input logic [63:0] v);
    reg_flat[64*idx +: 64] = v;
  endtask

  task automatic chk_cc(input string tag, input logic ez, input logic es, input logic eo);
    chk({tag, ".zf"}, 64'(zf), 64'(ez));
    chk({tag, ".sf"}, 64'(sf), 64'(es));
    chk({tag, ".of"}, 64'(of), 64'(eo));
  endtask

  initial begin
    rst_n       = 1'b1;
    pc          = 64'd0;
    instr_bytes = 80'd0;
    reg_flat    = '0;

    // Reset state with an all-zero (halt) instruction at pc 0
    #2 rst_n = 1'b0;
    #1;
    chk_cc("reset", 1'b1, 1'b0, 1'b0);
    chk("reset.halt", 64'(halt), 64'd1);
    chk("reset.valP", valP, 64'd1);
    chk("reset.rA", 64'(rA), 64'hF);
    chk("reset.invalid", 64'(invalid_instr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // irmovq $0x10,%rbx at 0x20
    @(negedge clk);
    pc          = 64'h20;
    instr_bytes = {64'h0000_0000_0000_0010, 8'hF3, 8'h30};
    #1;
    chk("irmovq.icode", 64'(icode), 64'h3);
    chk("irmovq.rA", 64'(rA), 64'hF);
    chk("irmovq.rB", 64'(rB), 64'h3);
    chk("irmovq.valC", valC, 64'h10);
    chk("irmovq.valE", valE, 64'h10);
    chk("irmovq.valP", valP, 64'h2A);
    @(posedge clk); #1;
    chk_cc("irmovq.cc", 1'b1, 1'b0, 1'b0);

    // addq with signed overflow: 1 + 0x7FFF...F
    @(negedge clk);
    set_reg(2, 64'h7FFF_FFFF_FFFF_FFFF);
    set_reg(3, 64'd1);
    pc          = 64'h40;
    instr_bytes = {64'd0, 8'h23, 8'h60};
    #1;
    chk("add.valA", valA, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("add.valB", valB, 64'd1);
    chk("add.valE", valE, 64'h8000_0000_0000_0000);
    chk("add.valP", valP, 64'h42);
    chk("add.cnd", 64'(cnd), 64'd0);
    @(posedge clk); #1;
    chk_cc("add.cc", 1'b0, 1'b1, 1'b1);

    // jl with sf=1, of=1 is not taken
    @(negedge clk);
    pc          = 64'h100;
    instr_bytes = {8'h00, 64'h0000_0000_0000_1234, 8'h72};
    #1;
    chk("jl_ovf.cnd", 64'(cnd), 64'd0);
    chk("jl_ovf.valC", valC, 64'h1234);
    chk("jl_ovf.valP", valP, 64'h109);
    chk("jl_ovf.rB", 64'(rB), 64'hF);
    @(posedge clk); #1;
    chk_cc("jl_ovf.cc", 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-operation: CC clears at once, datapath keeps tracking
    #2 rst_n = 1'b0;
    #1;
    chk_cc("midreset", 1'b1, 1'b0, 1'b0);
    chk("midreset.valP", valP, 64'h109);
    rst_n = 1'b1;

    // subq 3 - 5 = -2: negative, no overflow
    @(negedge clk);
    set_reg(2, 64'd5);
    set_reg(3, 64'd3);
    pc          = 64'h200;
    instr_bytes = {64'd0, 8'h23, 8'h61};
    #1;
    chk("sub_neg.valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk); #1;
    chk_cc("sub_neg.cc", 1'b0, 1'b1, 1'b0);

    // jl taken, jge not taken, cmovle taken under sf=1 of=0
    @(negedge clk);
    pc          = 64'h300;
    instr_bytes = {8'h00, 64'h0000_0000_0000_4000, 8'h72};
    #1;
    chk("jl.cnd", 64'(cnd), 64'd1);
    instr_bytes = {8'h00, 64'h0000_0000_0000_4000, 8'h75};
    #1;
    chk("jge.cnd", 64'(cnd), 64'd0);
    instr_bytes = {64'd0, 8'h23, 8'h21};
    #1;
    chk("cmovle.cnd", 64'(cnd), 64'd1);
    chk("cmovle.valE", valE, 64'd5);

    // OPq with ifun 6 is illegal and must not load CC
    @(negedge clk);
    instr_bytes = {64'd0, 8'h23, 8'h66};
    #1;
    chk("opq_bad.invalid", 64'(invalid_instr), 64'd1);
    @(posedge clk); #1;
    chk_cc("opq_bad.cc", 1'b0, 1'b1, 1'b0);

    // subq 5 - 5 = 0
    @(negedge clk);
    set_reg(3, 64'd5);
    instr_bytes = {64'd0, 8'h23, 8'h61};
    #1;
    chk("sub_zero.valE", valE, 64'd0);
    @(posedge clk); #1;
    chk_cc("sub_zero.cc", 1'b1, 1'b0, 1'b0);
    chk("je.pre", 64'(cnd), 64'd0);

    // pushq %rdx with rsp=0x100
    @(negedge clk);
    set_reg(4, 64'h100);
    set_reg(2, 64'hABCD);
    pc          = 64'h50;
    instr_bytes = {64'd0, 8'h2F, 8'hA0};
    #1;
    chk("push.valA", valA, 64'hABCD);
    chk("push.valB", valB, 64'h100);
    chk("push.valE", valE, 64'hF8);
    chk("push.valP", valP, 64'h52);

    // popq %rbx reads rsp on both ports
    instr_bytes = {64'd0, 8'h3F, 8'hB0};
    #1;
    chk("pop.valA", valA, 64'h100);
    chk("pop.valE", valE, 64'h108);
    chk("pop.rA", 64'(rA), 64'h3);

    // Undefined icode E
    instr_bytes = {72'd0, 8'hE0};
    #1;
    chk("e0.invalid", 64'(invalid_instr), 64'd1);
    chk("e0.halt", 64'(halt), 64'd0);

    // iaddq depends on the build option
    instr_bytes = {64'h0000_0000_0000_0007, 8'hF3, 8'hC0};
    #1;
`ifdef Y86_IADDQ_EN
    chk("iaddq.invalid", 64'(invalid_instr), 64'd0);
    chk("iaddq.valE", valE, 64'd12);
`else
    chk("iaddq.invalid", 64'(invalid_instr), 64'd1);
`endif

    // irmovq straddling the end of instruction memory
    @(negedge clk);
    pc          = 64'd1023;
    instr_bytes = {64'h0000_0000_0000_0010, 8'hF3, 8'h30};
    #1;
    chk("irm_edge.imem_err", 64'(imem_error), 64'd1);
    chk("irm_edge.invalid", 64'(invalid_instr), 64'd0);
    chk("irm_edge.halt", 64'(halt), 64'd0);

    // Overflowing add straddling the end: error blocks the CC load
    @(negedge clk);
    set_reg(2, 64'h7FFF_FFFF_FFFF_FFFF);
    set_reg(3, 64'd1);
    instr_bytes = {64'd0, 8'h23, 8'h60};
    #1;
    chk("opq_edge.imem_err", 64'(imem_error), 64'd1);
    @(posedge clk); #1;
    chk_cc("opq_edge.cc", 1'b1, 1'b0, 1'b0);

    // Same add ending exactly at the last byte is legal and loads CC
    @(negedge clk);
    pc = 64'd1022;
    #1;
    chk("opq_last.imem_err", 64'(imem_error), 64'd0);
    chk("opq_last.valP", valP, 64'd1024);
    @(posedge clk); #1;
    chk_cc("opq_last.cc", 1'b0, 1'b1, 1'b1);

    // One-byte halt in the last byte
    @(negedge clk);
    pc          = 64'd1023;
    instr_bytes = 80'd0;
    #1;
    chk("halt_last.halt", 64'(halt), 64'd1);
    chk("halt_last.imem_err", 64'(imem_error), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_y86_fde_core
`default_nettype wire
